// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, funct fields, FSM states and ALU operations for rv_mc_core (HALT exists only with RV_ILLEGAL_HALT_EN)
package rv_pkg;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR = 3'b101;
  localparam logic [2:0] F3_OR = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK
`ifdef RV_ILLEGAL_HALT_EN
    , HALT
`endif
  } state_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
endpackage

// File: rtl/rv_alu.sv
// rv_alu: combinational XLEN-wide integer ALU
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] sh;
  assign sh = op2[SW-1:0];
  always_comb begin
    case (op)
      ALU_ADD:  y = op1 + op2;
      ALU_SUB:  y = op1 - op2;
      ALU_SLL:  y = op1 << sh;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, op1 < op2};
      ALU_XOR:  y = op1 ^ op2;
      ALU_SRL:  y = op1 >> sh;
      ALU_SRA:  y = $unsigned($signed(op1) >>> sh);
      ALU_OR:   y = op1 | op2;
      ALU_AND:  y = op1 & op2;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/rv_mc_core.sv
// rv_mc_core: multi-cycle RV32E/RV32I ALU core with fetch handshake; RV_ILLEGAL_HALT_EN adds the illegal port and HALT state
module rv_mc_core
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] alu_result,
  output logic            retire
`ifdef RV_ILLEGAL_HALT_EN
  , output logic          illegal
`endif
);
  localparam int RW = $clog2(NUM_REGS);
  state_e state, nxt;
  logic [XLEN-1:0] pc, op1, op2, rs1_v, rs2_v, imm, alu_y;
  logic [31:0] instr;
  logic [XLEN-1:0] rf [NUM_REGS];
  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic is_r, is_i, shift_ok, r_ok, i_ok, idx_ok, legal, sub, sra;
  alu_op_e alu_op;
  assign opc = instr[6:0];
  assign rd = instr[11:7];
  assign f3 = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7 = instr[31:25];
  assign is_r = opc == OP_R;
  assign is_i = opc == OP_I;
  // shamt[5] only exists on RV64, so bit 25 must be clear for XLEN=32
  assign shift_ok = (instr[31:26] == 6'b0 || (f3 == F3_SR && instr[31:26] == 6'b010000)) && (XLEN == 64 || !instr[25]);
  assign r_ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
  assign i_ok = (f3 == F3_SLL || f3 == F3_SR) ? shift_ok : 1'b1;
  assign idx_ok = int'(rd) < NUM_REGS && int'(rs1) < NUM_REGS && (!is_r || int'(rs2) < NUM_REGS);
  assign legal = ((is_r && r_ok) || (is_i && i_ok)) && idx_ok;
  assign sub = is_r && f7[5];
  assign sra = instr[30];
  assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign rs1_v = (rs1 != 5'd0 && int'(rs1) < NUM_REGS) ? rf[rs1[RW-1:0]] : '0;
  assign rs2_v = (rs2 != 5'd0 && int'(rs2) < NUM_REGS) ? rf[rs2[RW-1:0]] : '0;
  assign imem_addr = pc;
  always_comb begin
    case (f3)
      F3_ADD:  alu_op = sub ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = sra ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end
  rv_alu #(.XLEN(XLEN)) u_alu (
    .op1(op1),
    .op2(op2),
    .op(alu_op),
    .y(alu_y)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      FETCH:     nxt = imem_ack ? DECODE : FETCH;
      DECODE:    nxt = EXECUTE;
`ifdef RV_ILLEGAL_HALT_EN
      EXECUTE:   nxt = legal ? WRITEBACK : HALT;
`else
      EXECUTE:   nxt = WRITEBACK;
`endif
      WRITEBACK: nxt = FETCH;
      default:   nxt = state;
    endcase
  end
  always_comb begin
    imem_req = state == FETCH && !reset;
`ifdef RV_ILLEGAL_HALT_EN
    illegal = state == HALT;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      instr <= '0;
      alu_result <= '0;
      retire <= 1'b0;
    end else begin
      retire <= 1'b0;
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (state == EXECUTE) begin
        if (legal) alu_result <= alu_y;
`ifdef RV_ILLEGAL_HALT_EN
        retire <= legal;
`else
        retire <= 1'b1;
`endif
      end
      if (state == WRITEBACK) pc <= pc + XLEN'(4);
    end
  end
  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      op1 <= rs1_v;
      op2 <= is_r ? rs2_v : imm;
    end
    if (!reset && state == WRITEBACK && legal && rd != 5'd0) rf[rd[RW-1:0]] <= alu_result;
  end
endmodule

// File: tb/tb_rv_mc_core.sv
// tb_rv_mc_core: directed table, randomized model-checked stream and reset/illegal corner sequences for rv_mc_core
module tb_rv_mc_core;
  logic clk = 1'b0;
  logic reset, imem_req, imem_ack, retire;
  logic [31:0] imem_addr, imem_rdata, alu_result;
`ifdef RV_ILLEGAL_HALT_EN
  logic illegal;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] regs [32];
  logic [31:0] pc_m, last_m;
  typedef struct {
    logic [31:0] ins;
    int waits;
    logic [31:0] exp;
  } vec_t;
  vec_t tab [16];
  always #5 clk = ~clk;
  rv_mc_core dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .alu_result(alu_result),
    .retire(retire)
`ifdef RV_ILLEGAL_HALT_EN
    , .illegal(illegal)
`endif
  );
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction
  // ISA-level reference: what the instruction means, with RV32E register limits
  function automatic void model(input logic [31:0] ins, output bit lg, output logic [31:0] r);
    int rd, rs1, rs2, f3, f7;
    bit isr, isi;
    logic [31:0] a, b;
    rd = int'(ins[11:7]);
    rs1 = int'(ins[19:15]);
    rs2 = int'(ins[24:20]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    isr = ins[6:0] == 7'h33;
    isi = ins[6:0] == 7'h13;
    a = (rs1 < 16) ? regs[rs1] : 32'h0;
    b = isr ? ((rs2 < 16) ? regs[rs2] : 32'h0) : {{20{ins[31]}}, ins[31:20]};
    lg = rd < 16 && rs1 < 16;
    if (isr) lg = lg && rs2 < 16 && (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
    else if (isi) lg = lg && (f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 32) : 1'b1);
    else lg = 1'b0;
    case (f3)
      0: r = (isr && f7 == 32) ? a - b : a + b;
      1: r = a << b[4:0];
      2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: r = (a < b) ? 32'd1 : 32'd0;
      4: r = a ^ b;
      5: r = (f7 == 32) ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      6: r = a | b;
      default: r = a & b;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  // Called at a negedge in FETCH; returns at the negedge after retire, back in FETCH
  task automatic exec(input logic [31:0] ins, input int waits, output logic [31:0] obs);
    bit lg;
    logic [31:0] r;
    model(ins, lg, r);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, pc_m);
    imem_ack = 1'b0;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, pc_m);
      chk("wait_retire", 32'(retire), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("decode_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("execute_retire", 32'(retire), 32'd0);
    @(negedge clk);
    if (lg && ins[11:7] != 5'd0) regs[ins[11:7]] = r;
    if (lg) last_m = r;
    pc_m = pc_m + 32'd4;
    chk("wb_retire", 32'(retire), 32'd1);
    chk("wb_result", alu_result, last_m);
    obs = alu_result;
    @(negedge clk);
    chk("post_retire", 32'(retire), 32'd0);
  endtask
  task automatic rand_instr(output logic [31:0] ins);
    int rd, rs1, rs2, f3, imm;
    rd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
    rs1 = $urandom_range(0, 15);
    rs2 = $urandom_range(0, 15);
    f3 = $urandom_range(0, 7);
`ifndef RV_ILLEGAL_HALT_EN
    if ($urandom_range(0, 15) == 0) rd = $urandom_range(16, 31);
`endif
    if ($urandom_range(0, 1) == 1) begin
      ins = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
    end else begin
      imm = (f3 == 1) ? $urandom_range(0, 31) :
            (f3 == 5) ? ($urandom_range(0, 1) * 1024 + $urandom_range(0, 31)) : $urandom_range(0, 4095);
      ins = enc_i(imm, rs1, f3, rd);
    end
  endtask
  initial begin
    logic [31:0] obs, ins, prev;
    tab[0] = '{enc_i(5, 0, 0, 1), 0, 32'd5};
    tab[1] = '{enc_i(-3, 0, 0, 2), 0, 32'hFFFF_FFFD};
    tab[2] = '{enc_r(0, 2, 1, 3, 3), 0, 32'd1};
    tab[3] = '{enc_r(0, 2, 1, 2, 4), 0, 32'd0};
    tab[4] = '{enc_i(12'h401, 2, 5, 5), 0, 32'hFFFF_FFFE};
    tab[5] = '{enc_i(7, 0, 0, 0), 3, 32'd7};
    tab[6] = '{enc_r(0, 1, 0, 0, 6), 0, 32'd5};
    tab[7] = '{enc_r(32, 2, 1, 0, 7), 0, 32'd8};
    tab[8] = '{enc_r(0, 1, 1, 1, 8), 0, 32'h0000_00A0};
    tab[9] = '{enc_i(28, 2, 5, 9), 0, 32'h0000_000F};
    tab[10] = '{enc_i(-1, 1, 3, 10), 0, 32'd1};
    tab[11] = '{enc_i(12'h7FF, 1, 4, 11), 2, 32'h0000_07FA};
    tab[12] = '{enc_i(12'h0F0, 2, 7, 12), 0, 32'h0000_00F0};
    tab[13] = '{enc_i(12'h800, 0, 6, 13), 0, 32'hFFFF_F800};
    tab[14] = '{enc_r(32, 1, 2, 5, 14), 1, 32'hFFFF_FFFF};
    tab[15] = '{enc_r(0, 3, 7, 0, 15), 0, 32'd9};
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    pc_m = 32'h0;
    last_m = 32'h0;
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_result", alu_result, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exec(tab[i].ins, tab[i].waits, obs);
      chk($sformatf("tab%0d", i), obs, tab[i].exp);
    end
    for (int i = 1; i < 16; i++) exec(enc_i($urandom_range(0, 4095), 0, 0, i), 0, obs);
    for (int i = 0; i < 150; i++) begin
      rand_instr(ins);
      exec(ins, $urandom_range(0, 2), obs);
    end
    // Out-of-range register index on RV32E
    ins = enc_r(0, 1, 1, 0, 20);
`ifdef RV_ILLEGAL_HALT_EN
    chk("ill_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_retire", 32'(retire), 32'd0);
    chk("ill_req_low", 32'(imem_req), 32'd0);
    chk("ill_pc", imem_addr, pc_m);
    repeat (3) @(negedge clk);
    chk("halt_flag", 32'(illegal), 32'd1);
    chk("halt_pc", imem_addr, pc_m);
    chk("halt_result", alu_result, last_m);
    reset = 1'b1;
    @(negedge clk);
    chk("halt_rst", 32'(illegal), 32'd0);
    reset = 1'b0;
    pc_m = 32'h0;
    last_m = 32'h0;
    @(negedge clk);
`else
    prev = last_m;
    exec(ins, 0, obs);
    chk("ill_result", obs, prev);
    chk("ill_pc", imem_addr, pc_m);
`endif
    exec(enc_r(0, 0, 4, 0, 1), 0, obs);
    // Reset while the instruction sits in EXECUTE; the ack during reset must be ignored
    exec(enc_i(11, 0, 0, 8), 0, obs);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    imem_rdata = enc_i(99, 0, 0, 8);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    chk("xrst_retire", 32'(retire), 32'd0);
    chk("xrst_pc", imem_addr, 32'h0);
    chk("xrst_result", alu_result, 32'h0);
    chk("xrst_req", 32'(imem_req), 32'd0);
    reset = 1'b0;
    imem_ack = 1'b0;
    pc_m = 32'h0;
    last_m = 32'h0;
    @(negedge clk);
    chk("xrst_req_up", 32'(imem_req), 32'd1);
    exec(enc_r(0, 0, 8, 0, 9), 0, obs);
    chk("x8_kept", obs, 32'd11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
